// File: rtl/au_cmd_sequencer_if.sv
// Command port plus load/read streaming handshakes between the bus/DMA
// front end (master) and au_cmd_sequencer (slave).
interface au_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_ctrl;
    logic [15:0] cmd_base;
    logic [8:0]  cmd_len;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dout;

    modport master (
        output cmd_valid, cmd_op, cmd_ctrl, cmd_base, cmd_len, din_valid, din, dout_ready,
        input  cmd_ready, din_ready, dout_valid, dout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ctrl, cmd_base, cmd_len, din_valid, din, dout_ready,
        output cmd_ready, din_ready, dout_valid, dout
    );
endinterface

// File: rtl/au_cmd_sequencer.sv
// Expands high-level ML-KEM core commands into the cycle-level control word,
// address and data stream, moving load/read bursts and watching au_end_op.
module au_cmd_sequencer #(
    parameter int TIMEOUT = 65535,
    parameter int GUARD   = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    au_cmd_sequencer_if.slave   bus,
    output logic [47:0]         au_control,
    output logic [15:0]         au_add,
    output logic [31:0]         au_data_in,
    input  logic [15:0]         au_data_out,
    input  logic                au_end_op,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic                err_cmd
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [7:0] PH_RESET  = 8'h00;
    localparam logic [7:0] PH_LOAD   = 8'h10;
    localparam logic [7:0] PH_SEED   = 8'h20;
    localparam logic [7:0] PH_START  = 8'h30;
    localparam logic [7:0] PH_READ   = 8'h40;
    localparam logic [7:0] PH_SHA3   = 8'h50;
    localparam logic [7:0] PH_RAND16 = 8'h60;
    localparam logic [7:0] PH_RAND8  = 8'h80;
    localparam logic [7:0] PH_IDLE   = 8'hF0;

    typedef enum logic [2:0] {
        OP_RESET, OP_LOAD, OP_LOAD_SEED, OP_START, OP_READ, OP_RESET_SHA3, OP_RAND, OP_ILLEGAL
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_LOAD, S_START, S_READ_ISSUE, S_READ_WAIT, S_READ_HOLD,
        S_RAND_GEN, S_RAND_CAP, S_FINISH
    } state_e;

    state_e        state;
    op_e           op_r;
    logic [31:0]   ctrl_r;
    logic [15:0]   base_r;
    logic [8:0]    len_r;
    logic [8:0]    idx;
    logic [TW-1:0] wait_cnt;
    logic [LW-1:0] lat_cnt;

    function automatic logic [47:0] ctl(input logic [7:0] ph, input logic [31:0] c);
        return {ph, 8'h00, c};
    endfunction

    // NOTE: every output is assigned here with <= for the state being entered,
    // so each output is a flop and the core sees a glitch-free stream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            op_r           <= OP_RESET;
            ctrl_r         <= '0;
            base_r         <= '0;
            len_r          <= '0;
            idx            <= '0;
            wait_cnt       <= '0;
            lat_cnt        <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.din_ready  <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.dout       <= '0;
            au_control     <= ctl(PH_IDLE, '0);
            au_add         <= '0;
            au_data_in     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_timeout    <= 1'b0;
            err_cmd        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    au_control    <= ctl(PH_IDLE, '0);
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_r          <= op_e'(bus.cmd_op);
                        ctrl_r        <= bus.cmd_ctrl;
                        base_r        <= bus.cmd_base;
                        len_r         <= bus.cmd_len;
                        idx           <= '0;
                        wait_cnt      <= '0;
                        err_timeout   <= 1'b0;
                        err_cmd       <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        case (op_e'(bus.cmd_op))
                            OP_RESET: begin
                                state      <= S_RST1;
                                au_control <= ctl(PH_RESET, bus.cmd_ctrl);
                            end
                            OP_RESET_SHA3: begin
                                state      <= S_RST1;
                                au_control <= ctl(PH_SHA3, bus.cmd_ctrl);
                            end
                            OP_START: begin
                                state      <= S_START;
                                au_control <= ctl(PH_START, bus.cmd_ctrl);
                            end
                            OP_LOAD, OP_LOAD_SEED, OP_READ, OP_RAND: begin
                                if (bus.cmd_len == '0) begin
                                    state <= S_FINISH;
                                    done  <= 1'b1;
                                end else if (op_e'(bus.cmd_op) == OP_READ) begin
                                    state      <= S_READ_ISSUE;
                                    au_control <= ctl(PH_READ, bus.cmd_ctrl);
                                    au_add     <= bus.cmd_base;
                                end else if (op_e'(bus.cmd_op) == OP_RAND) begin
                                    state      <= S_RAND_GEN;
                                    au_control <= ctl(bus.cmd_ctrl[0] ? PH_RAND8 : PH_RAND16, '0);
                                end else begin
                                    state         <= S_LOAD;
                                    bus.din_ready <= 1'b1;
                                end
                            end
                            default: begin
                                state   <= S_FINISH;
                                done    <= 1'b1;
                                err_cmd <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RST1: begin
                    state      <= S_FINISH;
                    done       <= 1'b1;
                    au_control <= ctl(PH_IDLE, '0);
                end
                S_LOAD: begin
                    if (bus.din_valid && bus.din_ready) begin
                        au_control    <= ctl(op_r == OP_LOAD_SEED ? PH_SEED : PH_LOAD, ctrl_r);
                        au_add        <= base_r + 16'(idx);
                        au_data_in    <= bus.din;
                        idx           <= idx + 9'd1;
                        bus.din_ready <= (idx + 9'd1) < len_r;
                    end else begin
                        au_control <= ctl(PH_IDLE, '0);
                        if (idx == len_r) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    // The flag may still be high from the previous operation,
                    // so it only counts once the guard window has passed.
                    if (au_end_op && wait_cnt >= TW'(GUARD)) begin
                        state      <= S_FINISH;
                        done       <= 1'b1;
                        au_control <= ctl(PH_IDLE, '0);
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= S_RST1;
                        err_timeout <= 1'b1;
                        au_control  <= ctl(PH_RESET, ctrl_r);
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_READ_ISSUE: begin
                    state   <= S_READ_WAIT;
                    lat_cnt <= LW'(1);
                end
                S_READ_WAIT: begin
                    if (lat_cnt == LW'(RD_LAT)) begin
                        state          <= S_READ_HOLD;
                        bus.dout       <= au_data_out;
                        bus.dout_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                S_READ_HOLD: begin
                    if (bus.dout_ready) begin
                        bus.dout_valid <= 1'b0;
                        idx            <= idx + 9'd1;
                        if ((idx + 9'd1) == len_r) begin
                            state      <= S_FINISH;
                            done       <= 1'b1;
                            au_control <= ctl(PH_IDLE, '0);
                        end else if (op_r == OP_RAND) begin
                            state      <= S_RAND_GEN;
                            au_control <= ctl(ctrl_r[0] ? PH_RAND8 : PH_RAND16, '0);
                        end else begin
                            state  <= S_READ_ISSUE;
                            au_add <= base_r + 16'(idx + 9'd1);
                        end
                    end
                end
                S_RAND_GEN: begin
                    state      <= S_RAND_CAP;
                    au_control <= ctl(PH_IDLE, '0);
                end
                S_RAND_CAP: begin
                    state          <= S_READ_HOLD;
                    bus.dout       <= au_data_out;
                    bus.dout_valid <= 1'b1;
                end
                S_FINISH: begin
                    state         <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                    busy          <= 1'b0;
                    au_control    <= ctl(PH_IDLE, '0);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_cmd_sequencer.sv
// Directed bench for au_cmd_sequencer: small core model returns addr^0x5A5A on
// reads and 0xA500+n on random-number cycles.
module tb_au_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] au_control;
    logic [15:0] au_add;
    logic [31:0] au_data_in;
    logic [15:0] au_data_out;
    logic        au_end_op;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        err_cmd;
    logic [7:0]  rnd_n = 8'd0;

    int checks = 0;
    int errors = 0;

    au_cmd_sequencer_if bus_if ();

    au_cmd_sequencer #(
        .TIMEOUT (100),
        .GUARD   (2),
        .RD_LAT  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .au_control  (au_control),
        .au_add      (au_add),
        .au_data_in  (au_data_in),
        .au_data_out (au_data_out),
        .au_end_op   (au_end_op),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_cmd     (err_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (au_control[47:40] == 8'h60 || au_control[47:40] == 8'h80) begin
            au_data_out <= 16'hA500 + {8'h00, rnd_n};
            rnd_n       <= rnd_n + 8'd1;
        end else begin
            au_data_out <= au_add ^ 16'h5A5A;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] ctrl,
                            input logic [15:0] base, input logic [8:0] len);
        int n = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_ctrl  = ctrl;
        bus_if.cmd_base  = base;
        bus_if.cmd_len   = len;
        while (!bus_if.cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", bus_if.cmd_ready, 1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic recv_word(input int stall, output logic [15:0] w, output int lat);
        logic stable = 1'b1;
        lat = 0;
        while (!bus_if.dout_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("dout_valid", bus_if.dout_valid, 1);
        w = bus_if.dout;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (bus_if.dout !== w || bus_if.dout_valid !== 1'b1) stable = 1'b0;
        end
        if (stall > 0) check("dout_stable", stable, 1);
        bus_if.dout_ready = 1'b1;
        @(negedge clk);
        bus_if.dout_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int          lat;
        int          good;
        int          k;

        rst               = 1'b0;
        au_end_op         = 1'b0;
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_op     = '0;
        bus_if.cmd_ctrl   = '0;
        bus_if.cmd_base   = '0;
        bus_if.cmd_len    = '0;
        bus_if.din_valid  = 1'b0;
        bus_if.din        = '0;
        bus_if.dout_ready = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_ctl", au_control, 48'hF000_0000_0000);
        check("rst_ready", bus_if.cmd_ready, 0);
        check("rst_outs", {busy, done, err_timeout, err_cmd, bus_if.dout_valid, bus_if.din_ready}, 0);
        check("rst_bus", {au_add, au_data_in, bus_if.dout}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", bus_if.cmd_ready, 1);

        // LOAD base 0x0010, len 4, back-to-back words 1..4
        send_cmd(3'd1, 32'h0, 16'h0010, 9'd4);
        check("ld_wait_ctl", au_control, 48'hF000_0000_0000);
        check("ld_din_ready", bus_if.din_ready, 1);
        bus_if.din_valid = 1'b1;
        bus_if.din       = 32'd1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus_if.din = 32'(i + 1);
            if (i == 4) bus_if.din_valid = 1'b0;
            check("ld_ctl", au_control, 48'h1000_0000_0000);
            check("ld_add", au_add, 64'(15 + i));
            check("ld_data", au_data_in, 64'(i));
        end
        @(negedge clk);
        check("ld_done", done, 1);
        check("ld_done_noready", bus_if.cmd_ready, 0);
        check("ld_fin_ctl", au_control, 48'hF000_0000_0000);
        @(negedge clk);
        check("ld_idle_ready", bus_if.cmd_ready, 1);
        check("ld_idle_done", done, 0);

        // LOAD_SEED base 0x0100, len 4, with a one-cycle din_valid gap after word 2
        send_cmd(3'd2, 32'hAA, 16'h0100, 9'd4);
        bus_if.din_valid = 1'b1;
        bus_if.din       = 32'h11;
        @(negedge clk);
        check("gp_ctl0", au_control, 48'h2000_0000_00AA);
        check("gp_w0", {au_add, au_data_in}, {16'h0100, 32'h11});
        bus_if.din = 32'h22;
        @(negedge clk);
        check("gp_w1", {au_add, au_data_in}, {16'h0101, 32'h22});
        bus_if.din_valid = 1'b0;
        @(negedge clk);
        check("gp_gap_ctl", au_control, 48'hF000_0000_0000);
        check("gp_gap_add", au_add, 16'h0101);
        bus_if.din_valid = 1'b1;
        bus_if.din       = 32'h33;
        @(negedge clk);
        check("gp_w2", {au_add, au_data_in}, {16'h0102, 32'h33});
        bus_if.din = 32'h44;
        @(negedge clk);
        check("gp_w3", {au_control[47:40], au_add, au_data_in}, {8'h20, 16'h0103, 32'h44});
        bus_if.din_valid = 1'b0;
        @(negedge clk);
        check("gp_done", done, 1);
        @(negedge clk);

        // LOAD with len 0: straight to FINISH
        send_cmd(3'd1, 32'h0, 16'h0040, 9'd0);
        check("ld0_done", done, 1);
        check("ld0_din_ready", bus_if.din_ready, 0);
        @(negedge clk);

        // START, end_op at cycle 1 (inside guard) and cycle 20
        send_cmd(3'd3, 32'h3, 16'h0, 9'd0);
        good = 0;
        for (int i = 0; i <= 20; i++) begin
            if (au_control == 48'h3000_0000_0003 && !done) good++;
            au_end_op = (i == 1 || i == 20);
            @(negedge clk);
        end
        au_end_op = 1'b0;
        check("st_hold", good, 21);
        check("st_done", done, 1);
        check("st_no_to", err_timeout, 0);
        @(negedge clk);

        // START with no end_op: timeout after 100 cycles
        send_cmd(3'd3, 32'h3, 16'h0, 9'd0);
        k = 0;
        while (au_control[47:40] != 8'h00 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("to_cycle", k, 100);
        check("to_ctl", au_control, 48'h0000_0000_0003);
        check("to_flag", err_timeout, 1);
        @(negedge clk);
        check("to_done", {done, au_control[47:40]}, {1'b1, 8'hF0});
        @(negedge clk);
        check("to_sticky", {bus_if.cmd_ready, err_timeout}, 2'b11);

        // READ base 0xFFFF, len 3, 5-cycle stall on the first word
        send_cmd(3'd4, 32'h55, 16'hFFFF, 9'd3);
        check("rd_err_clr", err_timeout, 0);
        check("rd_ctl", au_control, 48'h4000_0000_0055);
        check("rd_add0", au_add, 16'hFFFF);
        recv_word(4, w, lat);
        check("rd_w0", w, 16'hA5A5);
        check("rd_add1", au_add, 16'h0000);
        recv_word(0, w, lat);
        check("rd_w1", w, 16'h5A5A);
        check("rd_lat", lat, 2);
        check("rd_add2", au_add, 16'h0001);
        recv_word(0, w, lat);
        check("rd_w2", w, 16'h5A5B);
        check("rd_done", {done, bus_if.dout_valid}, 2'b10);
        @(negedge clk);

        // RAND len 2, byte mode
        send_cmd(3'd6, 32'h1, 16'h0, 9'd2);
        check("rn_ctl0", au_control, 48'h8000_0000_0000);
        recv_word(0, w, lat);
        check("rn_w0", w, 16'hA500);
        check("rn_lat", lat, 2);
        check("rn_ctl1", au_control, 48'h8000_0000_0000);
        recv_word(0, w, lat);
        check("rn_w1", w, 16'hA501);
        check("rn_done", done, 1);
        @(negedge clk);

        // Illegal opcode
        send_cmd(3'd7, 32'h0, 16'h0, 9'd0);
        check("il_done", {done, err_cmd}, 2'b11);
        @(negedge clk);
        check("il_sticky", {bus_if.cmd_ready, err_cmd}, 2'b11);

        // RESET_SHA3
        send_cmd(3'd5, 32'h1, 16'h0, 9'd0);
        check("sh_ctl", au_control, 48'h5000_0000_0001);
        check("sh_err_clr", err_cmd, 0);
        @(negedge clk);
        check("sh_done", done, 1);
        @(negedge clk);

        // Reset in the middle of a READ, then a fresh RESET command
        send_cmd(3'd4, 32'h0, 16'h0020, 9'd3);
        @(negedge clk);
        @(negedge clk);
        check("mr_hold", {bus_if.dout_valid, bus_if.dout}, {1'b1, 16'h5A7A});
        rst = 1'b0;
        @(negedge clk);
        check("mr_ctl", au_control, 48'hF000_0000_0000);
        check("mr_outs", {bus_if.dout_valid, bus_if.cmd_ready, busy, done}, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        check("mr_ready", {bus_if.cmd_ready, done}, 2'b10);
        send_cmd(3'd0, 32'hF, 16'h0, 9'd0);
        check("rs_ctl", au_control, 48'h0000_0000_000F);
        @(negedge clk);
        check("rs_done", {done, au_control[47:40]}, {1'b1, 8'hF0});
        @(negedge clk);
        check("rs_idle", {bus_if.cmd_ready, done, busy}, 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/au_cmd_sequencer.md
# au_cmd_sequencer

Command-driven sequencer for the ML-KEM arithmetic core. It accepts high-level commands (reset, load, load seed, start, read, SHA-3 reset, random) on a valid/ready port and expands each one into the cycle-level stream the core consumes: the 48-bit control word, address and data. It moves load and read bursts through two streaming ports and watches the core's end-of-operation flag with a timeout. It sits between the system bus/DMA front end and the arithmetic core.

## Interface
Parameters
- TIMEOUT, 65535: max cycles waiting for au_end_op in START before error.
- GUARD, 2: cycles after entering START during which au_end_op is ignored (stale flag).
- RD_LAT, 1: cycles from au_add issue to valid au_data_out.

Ports
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, command accepted on valid&ready.
- cmd_op  in  3  0 RESET, 1 LOAD, 2 LOAD_SEED, 3 START, 4 READ, 5 RESET_SHA3, 6 RAND, 7 illegal.
- cmd_ctrl  in  32  submodule controls, copied to au_control[31:0].
- cmd_base  in  16  first core address.
- cmd_len  in  9  word count, 0..256.
- din_valid / din_ready  in/out  1/1  load stream handshake.
- din  in  32  load word.
- dout_valid / dout_ready  out/in  1/1  read stream handshake.
- dout  out  16  read word.
- au_control  out  48  [47:40] phase, [39:32] zero, [31:0] ctrl.
- au_add  out  16  core address.
- au_data_in  out  32  core write data.
- au_data_out  in  16  core read data.
- au_end_op  in  1  core operation complete.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err_timeout  out  1  sticky, cleared on next accepted command.
- err_cmd  out  1  sticky, cleared on next accepted command.

## Operation
- Phase codes: 0x00 reset, 0x10 load, 0x20 seed, 0x30 start, 0x40 read, 0x50 sha3 reset, 0x60 rand 16-bit, 0x80 rand byte, 0xF0 idle/no-op.
- States: IDLE, RST1, LOAD, START, READ_ISSUE, READ_WAIT, READ_HOLD, RAND_GEN, RAND_CAP, FINISH.
- IDLE: cmd_ready=1, au_control=0xF0 in the phase field with ctrl=0. On accept, latch op/ctrl/base/len, set counter i=0, and clear error flags.
- RESET / RESET_SHA3: drive phase 0x00 / 0x50 with ctrl for one cycle (RST1), then FINISH.
- LOAD / LOAD_SEED: din_ready=1 while i<len.
  - Each accepted word is driven next cycle: au_data_in=din, au_add=base+i (mod 2^16), phase 0x10/0x20.
  - Cycles with no accepted word drive phase 0xF0 and perform no write.
  - After the len-th write cycle, go to FINISH.
- START: drive phase 0x30 with ctrl continuously.
  - After GUARD cycles, au_end_op=1 leads to FINISH.
  - If TIMEOUT cycles elapse without it, set err_timeout, drive phase 0x00 for one cycle (core reset), then FINISH.
- READ: phase 0x40 with ctrl throughout.
  - READ_ISSUE drives au_add=base+i.
  - READ_WAIT lasts RD_LAT cycles, then au_data_out is captured into dout.
  - READ_HOLD asserts dout_valid until dout_ready. Then i++, and the FSM goes to READ_ISSUE, or to FINISH at i=len.
- RAND:
  - RAND_GEN drives one cycle of phase 0x60, or 0x80 if ctrl[0]=1, with au_control[31:0]=0.
  - RAND_CAP drives phase 0xF0 and captures au_data_out, then follows the READ_HOLD handshake.
  - Repeat len times.
- cmd_len=0 on any burst op: no core access; FINISH next cycle.
- op 7: set err_cmd, FINISH.
- FINISH: done=1 for one cycle, phase 0xF0, then IDLE.

## Timing
- Reset (rst=0 at clk edge) output values:
  - au_control = 0xF00000000000; au_add, au_data_in and dout are 0.
  - cmd_ready=0 during reset, 1 the cycle after release.
  - All other outputs are 0.
  - State returns to IDLE. Reset mid-burst aborts it with no done pulse.
- All outputs are registered.
- Command accept to first core cycle: 1 cycle.
- Load throughput: 1 word/cycle with din_valid held high.
- Read throughput: 1 word per RD_LAT+2 cycles with dout_ready held high.
- dout and dout_valid must stay stable until handshake; dout_ready asserted early has no effect.
- Address arithmetic is 16-bit with wrap-around: base 0xFFFF, len 2 → addresses 0xFFFF then 0x0000.
- cmd_valid while busy: ignored; the command must be held by the sender.
- done and a new cmd_ready never occur in the same cycle; cmd_ready returns the cycle after done.

## Test plan
- LOAD base=0x0010, len=4, din=1,2,3,4 back-to-back → four cycles phase 0x10, add 0x10..0x13, data 1..4. Then done pulse, and idle phase 0xF0.
- LOAD with din_valid gap after word 2 → gap cycle shows phase 0xF0 and no address advance; total 4 writes.
- START ctrl=0x00000003, core raises au_end_op at cycle 1 (ignored) and cycle 20 → done at cycle 21.
  - Same command with au_end_op never raised, TIMEOUT=100 → err_timeout=1 and one phase 0x00 cycle, then done.
- READ base=0xFFFF, len=3, RD_LAT=1, dout_ready stalled 5 cycles on word 1 → addresses 0xFFFF, 0x0000, 0x0001. Words arrive in order, dout held stable during the stall.
- RAND len=2 ctrl[0]=1 → two phase 0x80 cycles, dout matches core data; then op 7 → err_cmd=1, done pulse.
- rst=0 in the middle of a READ → next cycle au_control=0xF00000000000 and dout_valid=0. After release, a fresh RESET command produces one phase 0x00 cycle and a done pulse.
